// File: rtl/counter_share_ctrl.sv
// Round-robin controller that lends one external binary counter to NREQ requesters.
// It clears the counter, enables it for the requested run, and cross-checks it against a shadow count.
module counter_share_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_clr,
  output logic                  cnt_en,
  input  logic [WIDTH-1:0]      cnt_q,
  output logic                  err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t             state, next_state;
  logic [IDX_W-1:0]   idx, ptr, win, scan_idx;
  logic               win_vld;
  logic [WIDTH-1:0]   tgt, exp_cnt;
  logic [WIDTH-1:0]   len_a [NREQ];
  logic               req_hold, at_tgt, abort;

  assign req_hold = req[idx];
  assign at_tgt   = (exp_cnt == tgt);
  assign abort    = ((state == CLEAR) || (state == RUN)) && !req_hold;

  always_comb begin
    for (int i = 0; i < NREQ; i++) len_a[i] = len[i*WIDTH +: WIDTH];
  end

  // Scan downward so the last hit is the requester closest after ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    win      = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      scan_idx = IDX_W'((int'(ptr) + k) % NREQ);
      if (req[scan_idx]) begin
        win     = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (win_vld) next_state = CLEAR;
      CLEAR: next_state = req_hold ? RUN : IDLE;
      RUN: begin
        if (!req_hold)   next_state = IDLE;
        else if (at_tgt) next_state = DONE;
      end
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Enable is driven from the shadow count, never from cnt_q, so a broken counter cannot stall us.
  always_comb begin
    busy    = (state != IDLE);
    cnt_clr = reset || (state == CLEAR);
    cnt_en  = (state == RUN) && !at_tgt && req_hold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      ptr     <= IDX_W'(NREQ - 1);
      idx     <= '0;
      tgt     <= '0;
      exp_cnt <= '0;
    end else begin
      done <= '0;
      if (state == IDLE && win_vld) begin
        idx <= win;
        tgt <= len_a[win];
        gnt <= NREQ'(1) << win;
      end
      if (state != IDLE && next_state == IDLE) gnt <= '0;

      unique case (state)
        CLEAR: exp_cnt <= '0;
        RUN: begin
          if (cnt_en) exp_cnt <= exp_cnt + WIDTH'(1);
          if (cnt_q != exp_cnt) err <= 1'b1;
          if (next_state == DONE) done <= NREQ'(1) << idx;
        end
        DONE: begin
          if (cnt_q != tgt) err <= 1'b1;
          ptr <= idx;
        end
        default: ;
      endcase

      if (abort) ptr <= idx;
    end
  end

endmodule
